// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h5400_0000;
    localparam int          DLX_WORD_BYTES    = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // The pc register adds one word to whatever it loads, so every load is pre-decremented.
    function automatic logic [31:0] pc_load_value(input logic [31:0] target);
        return target - 32'(DLX_WORD_BYTES);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with combinational head read and a synchronous clear that beats push/pop.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues instruction-memory requests from the pc register, pairs responses with
// their addresses, and queues them toward decode; drives the pc load port for stalls and branches.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  pc_i,
    output logic         pc_set_o,
    output logic [31:0]  pc_in_o,
    fetch_unit_if.master imem,
    input  logic         br_taken_i,
    input  logic [31:0]  br_target_i,
    output logic         id_valid_o,
    input  logic         id_ready_i,
    output logic [31:0]  id_instr_o,
    output logic [31:0]  id_pc_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] kill;
    logic [CW-1:0] q_count;
    logic [CW-1:0] addr_count;
    logic [CW:0]   in_use;
    logic          room;
    logic          grant;
    logic          q_pop;
    logic          q_push;
    logic          rst_done;
    logic [31:0]   addr_head;
    fetch_entry_t  q_head;
    fetch_entry_t  q_entry;

    // Suppresses issue in the first cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    assign q_pop  = id_valid_o && id_ready_i;
    assign in_use = {1'b0, outstanding} + {1'b0, q_count} - (CW+1)'(q_pop);
    assign room   = in_use < (CW+1)'(DEPTH);

    assign imem.req  = room && !br_taken_i && rst_done;
    assign imem.addr = pc_i;
    assign grant     = imem.req && imem.gnt;

    always_comb begin
        pc_set_o = 1'b0;
        pc_in_o  = '0;
        if (reset_n) begin
            if (br_taken_i) begin
                pc_set_o = 1'b1;
                pc_in_o  = pc_load_value(br_target_i);
            end else if (!grant) begin
                pc_set_o = 1'b1;
                pc_in_o  = pc_load_value(pc_i);
            end
        end
    end

    assign outstanding_next = outstanding + CW'(grant) - CW'(imem.rvalid);

    // On a flush every response still in flight after this cycle belongs to the wrong path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            kill        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (br_taken_i) begin
                kill <= outstanding_next;
            end else if (imem.rvalid && (kill != '0)) begin
                kill <= kill - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [31:0])
    ) u_addr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (1'b0),
        .push      (grant),
        .push_data (imem.addr),
        .pop       (imem.rvalid),
        .head      (addr_head),
        .count     (addr_count)
    );

    assign q_push  = imem.rvalid && (kill == '0) && !br_taken_i;
    assign q_entry = '{pc: addr_head, instr: imem.rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_decode_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (br_taken_i),
        .push      (q_push),
        .push_data (q_entry),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    assign id_valid_o = (q_count != '0);
    assign id_instr_o = id_valid_o ? q_head.instr : NOP_INSTR;
    assign id_pc_o    = id_valid_o ? q_head.pc : '0;

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem.rvalid |-> ((outstanding != '0) && (addr_count != '0))
    );

endmodule
